// File: rtl/ov7670_pkg.sv
// Shared constants, state encoding and pixel-sum types for the OV7670
// 2x2 box-filter downscaler.
package ov7670_pkg;

    localparam int IN_W       = 640;
    localparam int IN_H       = 480;
    localparam int OUT_W      = 320;
    localparam int OUT_H      = 240;
    localparam int OUT_PIXELS = 76800;

    // RGB565 field positions
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    // Horizontal pair sum: one extra bit per channel (6/7/6)
    typedef struct packed {
        logic [5:0] r;
        logic [6:0] g;
        logic [5:0] b;
    } hsum_t;

    // Per-channel sum of two RGB565 pixels
    function automatic hsum_t add_pix(input logic [15:0] p0, input logic [15:0] p1);
        hsum_t s;
        s.r = {1'b0, p0[R_MSB:R_LSB]} + {1'b0, p1[R_MSB:R_LSB]};
        s.g = {1'b0, p0[G_MSB:G_LSB]} + {1'b0, p1[G_MSB:G_LSB]};
        s.b = {1'b0, p0[B_MSB:B_LSB]} + {1'b0, p1[B_MSB:B_LSB]};
        return s;
    endfunction

endpackage

// File: rtl/ov7670_downscale_2x2_if.sv
// Pixel-in / frame-buffer-out bundle of the downscaler.
interface ov7670_downscale_2x2_if #(
    parameter int ADDR_W = 17
);
    logic              in_we;
    logic [15:0]       in_data;
    logic              in_eof;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    logic [15:0]       out_data;
    logic              frame_done;

    // Pixel source / frame-buffer sink side
    modport master (
        output in_we, in_data, in_eof,
        input  out_we, out_addr, out_data, frame_done
    );

    // Downscaler side
    modport slave (
        input  in_we, in_data, in_eof,
        output out_we, out_addr, out_data, frame_done
    );
endinterface

// File: rtl/linebuf_320x19.sv
// Simple dual-port line buffer: one write port, one registered read port.
module linebuf_320x19 #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 19,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Synchronous read, output holds until the next read
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/ov7670_downscale_2x2.sv
// 2x2 box-filter downscaler: RGB565 camera stream in, half-size image
// written to a frame buffer through a single write port.
module ov7670_downscale_2x2
    import ov7670_pkg::*;
#(
    parameter int IN_W   = ov7670_pkg::IN_W,
    parameter int IN_H   = ov7670_pkg::IN_H,
    parameter int ADDR_W = 17
) (
    input  logic                  pclk,
    input  logic                  rst,
    ov7670_downscale_2x2_if.slave bus
);
    localparam int HALF_W = IN_W / 2;
    localparam int XW     = $clog2(IN_W);
    localparam int YW     = $clog2(IN_H);

    state_t            state_r;
    state_t            state_s;
    logic              accept_s;
    logic [XW-1:0]     in_x_r;
    logic [YW-1:0]     in_y_r;
    logic [15:0]       hold_r;
    logic              x_last_s;
    logic              y_last_s;
    logic              frame_last_s;
    logic              wr_s;
    hsum_t             hsum_s;
    hsum_t             lb_q_s;
    logic [18:0]       lb_rdata;
    logic              lb_we_s;
    logic              lb_re_s;
    logic [6:0]        tot_r_s;
    logic [7:0]        tot_g_s;
    logic [6:0]        tot_b_s;
    logic [15:0]       pix_s;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] y2_s;
    logic [ADDR_W-1:0] x2_s;
    logic              out_we_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic [15:0]       out_data_r;
    logic              frame_done_r;

    assign x_last_s     = (in_x_r == XW'(IN_W - 1));
    assign y_last_s     = (in_y_r == YW'(IN_H - 1));
    assign frame_last_s = accept_s && x_last_s && y_last_s;

    // FSM state register
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_r <= ST_WAIT_SOF;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: in_eof always (re)starts a frame
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_WAIT_SOF: begin
                if (bus.in_eof) state_s = ST_ACTIVE;
                else            state_s = ST_WAIT_SOF;
            end
            ST_ACTIVE: begin
                if (bus.in_eof)        state_s = ST_ACTIVE;
                else if (frame_last_s) state_s = ST_DONE;
                else                   state_s = ST_ACTIVE;
            end
            ST_DONE: begin
                if (bus.in_eof) state_s = ST_ACTIVE;
                else            state_s = ST_DONE;
            end
            default: state_s = ST_WAIT_SOF;
        endcase
    end

    // FSM outputs: pixels count only while active, and in_eof drops a coincident pixel
    always_comb begin
        accept_s = 1'b0;
        case (state_r)
            ST_ACTIVE: accept_s = bus.in_we && !bus.in_eof;
            default:   accept_s = 1'b0;
        endcase
    end

    // Raster position counters
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            in_x_r <= '0;
            in_y_r <= '0;
        end else if (bus.in_eof) begin
            in_x_r <= '0;
            in_y_r <= '0;
        end else if (accept_s) begin
            if (x_last_s) begin
                in_x_r <= '0;
                in_y_r <= y_last_s ? '0 : in_y_r + YW'(1);
            end else begin
                in_x_r <= in_x_r + XW'(1);
            end
        end else begin
            in_x_r <= in_x_r;
            in_y_r <= in_y_r;
        end
    end

    // Hold the even-x pixel until its odd-x partner arrives
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hold_r <= 16'h0000;
        end else if (bus.in_eof) begin
            hold_r <= 16'h0000;
        end else if (accept_s && !in_x_r[0]) begin
            hold_r <= bus.in_data;
        end else begin
            hold_r <= hold_r;
        end
    end

    assign hsum_s = add_pix(hold_r, bus.in_data);

    // Even lines store pair sums; odd lines prefetch them on the even-x pixel
    assign lb_we_s = accept_s &&  in_x_r[0] && !in_y_r[0];
    assign lb_re_s = accept_s && !in_x_r[0] &&  in_y_r[0];
    assign wr_s    = accept_s &&  in_x_r[0] &&  in_y_r[0];

    linebuf_320x19 #(
        .DEPTH (HALF_W),
        .WIDTH (19)
    ) u_linebuf (
        .clk   (pclk),
        .we    (lb_we_s),
        .waddr (in_x_r[XW-1:1]),
        .wdata (hsum_s),
        .re    (lb_re_s),
        .raddr (in_x_r[XW-1:1]),
        .rdata (lb_rdata)
    );

    assign lb_q_s  = hsum_t'(lb_rdata);
    assign tot_r_s = {1'b0, hsum_s.r} + {1'b0, lb_q_s.r};
    assign tot_g_s = {1'b0, hsum_s.g} + {1'b0, lb_q_s.g};
    assign tot_b_s = {1'b0, hsum_s.b} + {1'b0, lb_q_s.b};
    assign pix_s   = {tot_r_s[6:2], tot_g_s[7:2], tot_b_s[6:2]};

    assign y2_s = ADDR_W'(in_y_r[YW-1:1]);
    assign x2_s = ADDR_W'(in_x_r[XW-1:1]);

    // Output address: shift-add for the 320-wide case, constant scaling otherwise
    always_comb begin
        addr_s = '0;
        if (IN_W == 640) begin
            addr_s = (y2_s << 8) + (y2_s << 6) + x2_s;
        end else begin
            addr_s = y2_s * ADDR_W'(HALF_W) + x2_s;
        end
    end

    // Registered frame-buffer write port
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            out_we_r     <= 1'b0;
            out_addr_r   <= '0;
            out_data_r   <= 16'h0000;
            frame_done_r <= 1'b0;
        end else if (wr_s) begin
            out_we_r     <= 1'b1;
            out_addr_r   <= addr_s;
            out_data_r   <= pix_s;
            frame_done_r <= frame_last_s;
        end else begin
            out_we_r     <= 1'b0;
            out_addr_r   <= out_addr_r;
            out_data_r   <= out_data_r;
            frame_done_r <= 1'b0;
        end
    end

    assign bus.out_we     = out_we_r;
    assign bus.out_addr   = out_addr_r;
    assign bus.out_data   = out_data_r;
    assign bus.frame_done = frame_done_r;
endmodule
